pc_sequencer: RTL

Owns the fetch program counter of the pipelined MIPS core and decides every cycle where fetch goes next: sequential, branch target, jump target, exception vector or EPC. Accepts redirect requests from the ID-stage branch/jump logic and the exception unit, and stall requests from the hazard unit. Holds redirects that arrive while fetch is stalled until the stall releases. Drives the IF/ID flush for wrong-path instructions. Sits between the hazard unit, the ID-stage branch comparator and the instruction memory address port.

---
 rtl/pc_seq_pkg.sv | 46 ++++
 rtl/pc_target.sv | 11 +
 rtl/pc_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch PC sequencer.
// State enum, reset/exception addresses, request priority.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

  // One-hot request vector; higher index wins.
  localparam int REQ_W     = 6;
  localparam int REQ_SEQ   = 0;
  localparam int REQ_STALL = 1;
  localparam int REQ_BR    = 2;
  localparam int REQ_JUMP  = 3;
  localparam int REQ_ERET  = 4;
  localparam int REQ_EXC   = 5;

  // Keep only the highest-priority raised request.
  function automatic logic [REQ_W-1:0] req_pick(
    input logic [REQ_W-1:0] raw
  );
    logic [REQ_W-1:0] sel;
    logic             found;
    sel   = '0;
    found = 1'b0;
    for (int i = REQ_W - 1; i >= 0; i--) begin
      if (raw[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_target.sv
// Branch target adder: br_pc4 + (br_off << 2), wrapping.
// Ports: br_pc4, br_off in; br_target out.
module pc_target (
  input  logic [31:0] br_pc4,
  input  logic [31:0] br_off,
  output logic [31:0] br_target
);

  assign br_target = br_pc4 + {br_off[29:0], 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: next-pc mux, pending-redirect FSM, IF flush.
// In: reset, stall, branch/jump/exc/eret; out: pc, flush, status.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        br_valid,
  input  logic        br_zero,
  input  logic [31:0] br_pc4,
  input  logic [31:0] br_off,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush_if,
  output logic        align_err,
  output logic        redirect_pending
);

  localparam logic [1:0] CNT_LOAD =
    2'(FLUSH_CYCLES - 1);
  localparam logic MULTI_FLUSH =
    (FLUSH_CYCLES > 1);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [1:0]  cnt_q, cnt_d;

  logic [31:0]      br_target;
  logic [31:0]      redir_tgt;
  logic [31:0]      apply_tgt;
  logic             do_apply;
  logic             in_pend;
  logic             flush_c;
  logic             aerr_c;
  logic [REQ_W-1:0] raw;
  logic [REQ_W-1:0] sel;

  pc_target u_target (
    .br_pc4    (br_pc4),
    .br_off    (br_off),
    .br_target (br_target)
  );

  assign in_pend   = (state_q == PEND);
  assign redir_tgt = jump_valid ? jump_target
                                : br_target;

  // Older pending redirect masks new jump/branch.
  always_comb begin
    raw            = '0;
    raw[REQ_EXC]   = exc_req;
    raw[REQ_ERET]  = eret_req;
    raw[REQ_JUMP]  = jump_valid & ~in_pend;
    raw[REQ_BR]    = br_valid & br_zero
                   & ~in_pend;
    raw[REQ_STALL] = stall_i;
    raw[REQ_SEQ]   = 1'b1;
  end

  assign sel = req_pick(raw);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q + 32'd4;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    do_apply  = 1'b0;
    apply_tgt = '0;
    flush_c   = (state_q == FLUSH);
    aerr_c    = 1'b0;

    unique case (1'b1)
      sel[REQ_EXC]: begin
        do_apply  = 1'b1;
        apply_tgt = EXC_VECTOR;
      end
      sel[REQ_ERET]: begin
        do_apply  = 1'b1;
        apply_tgt = epc;
      end
      sel[REQ_JUMP],
      sel[REQ_BR]: begin
        if (stall_i) begin
          pc_d    = pc_q;
          tgt_d   = redir_tgt;
          cnt_d   = '0;
          state_d = PEND;
        end else begin
          do_apply  = 1'b1;
          apply_tgt = redir_tgt;
        end
      end
      sel[REQ_STALL]: begin
        pc_d = pc_q;
      end
      default: begin
        if (in_pend) begin
          do_apply  = 1'b1;
          apply_tgt = tgt_q;
        end else if (state_q == FLUSH) begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
    endcase

    if (do_apply) begin
      pc_d    = word_align(apply_tgt);
      aerr_c  = |apply_tgt[1:0];
      flush_c = 1'b1;
      tgt_d   = '0;
      if (MULTI_FLUSH) begin
        state_d = FLUSH;
        cnt_d   = CNT_LOAD;
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc               = pc_q;
  assign pc_plus4         = pc_q + 32'd4;
  assign flush_if         = flush_c & ~reset;
  assign align_err        = aerr_c & ~reset;
  assign redirect_pending = in_pend;

endmodule
